// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch slice.
package fetch_pkg;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake carrying an instruction and its byte address.
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_unit_fifo.sv
// Power-of-two circular buffer of {pc, instr} entries with synchronous flush.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[tail_q] <= wdata;
        tail_q      <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem[head_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// Fetch controller: owns the PC, reads combinational imem, buffers words toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master          dec
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0]   pc_q;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  logic [2*DATA_WIDTH-1:0] head;

  assign imem_addr = pc_q;
  assign pop       = dec.out_valid & dec.out_ready;
  // A pop frees the slot this same edge, so a full FIFO still accepts a word.
  assign push      = ~redirect_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~(DATA_WIDTH'(INSTR_BYTES - 1));
    end else if (push) begin
      pc_q <= pc_q + DATA_WIDTH'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc_q, imem_rdata}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    dec.out_valid = ~empty;
    dec.out_instr = DATA_WIDTH'(NOP_INSTR);
    dec.out_pc    = '0;
    if (!empty) begin
      dec.out_instr = head[DATA_WIDTH-1:0];
      dec.out_pc    = head[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (rst)
    (count <= CW'(DEPTH)) && (full == (count == CW'(DEPTH))));
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected PC stream queue vs. accepted decode outputs.
module tb_fetch_unit;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WRAP0 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] w_addr, w_rdata;

  fetch_unit_if #(.DATA_WIDTH(32)) dv ();
  fetch_unit_if #(.DATA_WIDTH(32)) wv ();

  fetch_unit #(.DATA_WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dv.master)
  );

  fetch_unit #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(WRAP0)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (w_addr),
    .imem_rdata     (w_rdata),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .dec            (wv.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a >> 2;
  endfunction

  assign imem_rdata   = rom(imem_addr);
  assign w_rdata      = rom(w_addr);
  assign wv.out_ready = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;
  int w_pops      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = '0;
  logic [31:0] w_exp  = WRAP0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; retarget the expected stream on whatever reset/redirect that edge saw.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      gen_pc = 32'h0;
    end else if (redirect_valid) begin
      exp_q.delete();
      gen_pc = {redirect_pc[31:2], 2'b00};
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] p;
    if (!rst) begin
      if (dv.out_valid && dv.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          p = exp_q.pop_front();
          chk("out_pc", dv.out_pc, p);
          chk("out_instr", dv.out_instr, rom(p));
          pops++;
        end
      end else if (!dv.out_valid) begin
        chk("idle_instr", dv.out_instr, NOP);
        chk("idle_pc", dv.out_pc, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      w_exp = WRAP0;
    end else if (wv.out_valid) begin
      chk("wrap_pc", wv.out_pc, w_exp);
      chk("wrap_instr", wv.out_instr, rom(w_exp));
      w_exp = w_exp + 32'd4;
      w_pops++;
    end
  end

  initial begin
    int rand_pops;
    dv.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(dv.out_valid), 32'd0);
    chk("rst_instr", dv.out_instr, NOP);
    chk("rst_pc", dv.out_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    rst = 1'b0;
    tick();
    chk("first_valid", 32'(dv.out_valid), 32'd1);
    repeat (5) begin
      tick();
      chk("stall_addr", imem_addr, 32'd8);
      chk("stall_pc", dv.out_pc, 32'h0);
      chk("stall_instr", dv.out_instr, 32'h0);
      chk("stall_valid", 32'(dv.out_valid), 32'd1);
    end
    dv.out_ready = 1'b1;
    repeat (6) tick();

    dv.out_ready = 1'b0;
    repeat (3) tick();
    dv.out_ready   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    chk("redir_bubble", 32'(dv.out_valid), 32'd0);
    tick();
    chk("redir_pc", dv.out_pc, 32'h40);
    chk("redir_instr", dv.out_instr, 32'h10);
    repeat (3) tick();

    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("dbl_bubble", 32'(dv.out_valid), 32'd0);
    tick();
    chk("dbl_pc", dv.out_pc, 32'h200);
    repeat (4) tick();

    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    chk("rst_redir_addr", imem_addr, 32'h0);
    chk("rst_redir_valid", 32'(dv.out_valid), 32'd0);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    tick();

    rand_pops = pops;
    for (int i = 0; i < 10000; i++) begin
      dv.out_ready   = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    dv.out_ready   = 1'b1;
    repeat (4) tick();

    chk("rand_throughput", 32'(pops - rand_pops > 4000), 32'd1);
    chk("wrap_progress", 32'(w_pops > 100), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch controller for the single-cycle/pipelined RISC-V core. Owns the program counter, drives the byte address into the combinational instruction memory, and buffers fetched words in a small FIFO toward decode. Supports valid/ready backpressure from decode and a one-cycle redirect (branch/jump/trap) that flushes buffered instructions and reloads the PC.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction and address width
- DEPTH, 2, FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, PC loaded on reset; word-aligned

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  DATA_WIDTH  byte address to instruction memory; equals pc_q
- imem_rdata  in  DATA_WIDTH  instruction word, combinational in imem_addr, same cycle
- redirect_valid  in  1  load new PC and flush this cycle
- redirect_pc  in  DATA_WIDTH  target byte address; bits [1:0] ignored
- out_valid  out  1  FIFO head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  DATA_WIDTH  head instruction; NOP (32'h0000_0013) when out_valid=0
- out_pc  out  DATA_WIDTH  byte address of out_instr; 0 when out_valid=0

## Operation
- pc_q: fetch PC register. imem_addr = pc_q at all times.
- pop = out_valid & out_ready. push = ~redirect_valid & (~full | pop).
- On push: write {pc_q, imem_rdata} at tail; pc_q <= pc_q + 4, modulo 2^DATA_WIDTH (0xFFFF_FFFC wraps to 0x0).
- Full with no pop: no push, pc_q holds, imem_addr stable.
- Simultaneous push and pop when full: both occur, count unchanged.
- Redirect (highest priority): pc_q <= {redirect_pc[31:2], 2'b00}; FIFO cleared (count=0, pointers 0); no push that cycle. A pop asserted in the same cycle counts as accepted by decode; the entry is discarded regardless.
- Redirect while empty, full, or on consecutive cycles: same rule each cycle; last redirect wins.
- FIFO: head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH; count of log2(DEPTH)+1 bits, 0..DEPTH. full = (count==DEPTH), empty = (count==0).
- Outputs taken from head entry; masked to NOP / 0 when empty.
- No explicit FSM; behaviour fully defined by pc_q and FIFO count.

## Timing
- Reset (rst=1 at an edge): pc_q=RESET_PC, count=0, pointers=0; out_valid=0, out_instr=NOP, out_pc=0, imem_addr=RESET_PC. rst dominates redirect_valid.
- Reset mid-operation discards all buffered entries; no partial state survives.
- First cycle after reset release: push of RESET_PC word; out_valid=1 from the following cycle.
- Fetch-to-output latency: 1 cycle (word pushed at edge N visible at head after edge N).
- Redirect-to-output latency: redirect at edge N, out_valid=0 after N, target instruction at head after N+1.
- Steady state with out_ready=1: one instruction per cycle, consecutive PCs.
- out_* are functions of registered state only; no combinational path from out_ready or redirect_* to out_*. imem_addr depends only on pc_q.

## Structure
- Package fetch_pkg: INSTR_BYTES=4, NOP_INSTR=32'h0000_0013, RESET_PC_DEFAULT=32'h0.
- Sub-module fetch_fifo (parameterized DEPTH, entry width 2*DATA_WIDTH, push/pop/flush, full/empty/count, head data). fetch_unit holds pc_q and handshake logic.

## Test plan
- Reset then out_ready=1 with ROM word[i]=i: out_pc 0,4,8,... and out_instr 0,1,2,... one per cycle, first out_valid one cycle after reset release.
- out_ready=0 for 5 cycles after fill: count=DEPTH, pc_q=4*DEPTH, outputs stable; release out_ready -> resumes with no loss or duplication.
- Redirect to 0x43 while full and out_ready=1: next cycle out_valid=0; following cycle out_pc=0x40, out_instr=ROM[0x10].
- RESET_PC=0xFFFF_FFF8, out_ready=1: out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Redirect asserted on two consecutive cycles (0x100 then 0x200): only 0x200 stream appears; rst asserted with redirect_valid=1 -> pc_q=RESET_PC, FIFO empty.
- Random out_ready/redirect for 10k cycles vs. reference model: every accepted (out_pc, out_instr) matches ROM[out_pc>>2] and expected PC sequence.
